// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multicycle sequencer and the shared
// memory / register-file / ALU datapath.
interface multicycle_ctrl_if;
  logic [31:0] inst;
  logic        zero;
  logic        mem_ack;
  logic        mem_rd;
  logic        mem_wr;
  logic        i_or_d;
  logic        ir_wr;
  logic        pc_wr;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic        ext_op;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        reg_wr;
  logic        retire;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [3:0]  state;

  modport master (
    input  inst, zero, mem_ack,
    output mem_rd, mem_wr, i_or_d, ir_wr, pc_wr, pc_src, alu_src_a, alu_src_b,
           alu_op, ext_op, reg_dst, mem_to_reg, reg_wr, retire, trap, trap_cause, state
  );

  modport slave (
    output inst, zero, mem_ack,
    input  mem_rd, mem_wr, i_or_d, ir_wr, pc_wr, pc_src, alu_src_a, alu_src_b,
           alu_op, ext_op, reg_dst, mem_to_reg, reg_wr, retire, trap, trap_cause, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the MIPS-subset datapath: walks each instruction through
// fetch/decode/execute/memory/writeback, with memory-handshake timeout and illegal-op traps.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT     = 15,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_TRAP      = 4'd15
  } state_t;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       i_or_d;
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       ext_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_wr;
    logic       retire;
    logic       trap;
    logic [1:0] trap_cause;
    logic [3:0] state;
  } ctl_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_MEM     = 2'b10;

  state_t     cur, nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic [1:0] cause_q, cause_nxt;
  logic [5:0] op, funct;
  logic       r_ok;
  logic [2:0] r_aop;
  logic       timed_out;
  ctl_t       c, o;
  logic       unused_inst_bits;

  assign op               = bus.inst[31:26];
  assign funct            = bus.inst[5:0];
  assign timed_out        = (wait_cnt == 8'(MEM_TIMEOUT));
  assign unused_inst_bits = ^bus.inst[25:6];

  always_comb begin
    r_ok  = 1'b1;
    r_aop = ALU_ADD;
    case (funct)
      6'h20:   r_aop = ALU_ADD;
      6'h22:   r_aop = ALU_SUB;
      6'h24:   r_aop = ALU_AND;
      6'h25:   r_aop = ALU_OR;
      6'h2A:   r_aop = ALU_SLT;
      6'h00:   r_aop = ALU_SLL;
      default: r_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= S_FETCH;
      wait_cnt <= '0;
      cause_q  <= '0;
    end else begin
      cur      <= nxt;
      wait_cnt <= wait_nxt;
      cause_q  <= cause_nxt;
    end
  end

  // wait_nxt defaults to 0 so any state change (or ack) clears the timeout count.
  always_comb begin
    c         = '0;
    nxt       = cur;
    wait_nxt  = '0;
    cause_nxt = cause_q;
    c.state   = cur;
    case (cur)
      S_FETCH: begin
        c.mem_rd    = 1'b1;
        c.alu_src_b = 2'b01;
        if (bus.mem_ack) begin
          c.ir_wr = 1'b1;
          c.pc_wr = 1'b1;
          nxt     = S_DECODE;
        end else if (timed_out) begin
          nxt       = S_TRAP;
          cause_nxt = CAUSE_MEM;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.ext_op    = 1'b1;
        if (op == OP_R && r_ok)              nxt = S_EXEC_R;
        else if (op == OP_LW || op == OP_SW) nxt = S_MEM_ADDR;
        else if (op == OP_ADDI)              nxt = S_EXEC_I;
        else if (op == OP_BEQ || op == OP_BNE) nxt = S_BRANCH;
        else if (op == OP_J)                 nxt = S_JUMP;
        else if (TRAP_ON_ILLEGAL) begin
          nxt       = S_TRAP;
          cause_nxt = CAUSE_ILLEGAL;
        end else begin
          nxt = S_FETCH;
        end
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.ext_op    = 1'b1;
        nxt         = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        c.mem_rd = 1'b1;
        c.i_or_d = 1'b1;
        if (bus.mem_ack) begin
          nxt = S_MEM_WB;
        end else if (timed_out) begin
          nxt       = S_TRAP;
          cause_nxt = CAUSE_MEM;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      S_MEM_WB: begin
        c.reg_wr     = 1'b1;
        c.mem_to_reg = 1'b1;
        c.retire     = 1'b1;
        nxt          = S_FETCH;
      end
      S_MEM_WRITE: begin
        c.mem_wr = 1'b1;
        c.i_or_d = 1'b1;
        if (bus.mem_ack) begin
          c.retire = 1'b1;
          nxt      = S_FETCH;
        end else if (timed_out) begin
          nxt       = S_TRAP;
          cause_nxt = CAUSE_MEM;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = r_aop;
        nxt         = S_R_WB;
      end
      S_R_WB: begin
        c.reg_wr  = 1'b1;
        c.reg_dst = 1'b1;
        c.alu_op  = r_aop;
        c.retire  = 1'b1;
        nxt       = S_FETCH;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.ext_op    = 1'b1;
        nxt         = S_I_WB;
      end
      S_I_WB: begin
        c.reg_wr = 1'b1;
        c.retire = 1'b1;
        nxt      = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
        c.pc_src    = 2'b01;
        c.pc_wr     = ((op == OP_BEQ) && bus.zero) || ((op == OP_BNE) && !bus.zero);
        c.retire    = 1'b1;
        nxt         = S_FETCH;
      end
      S_JUMP: begin
        c.pc_src = 2'b10;
        c.pc_wr  = 1'b1;
        c.retire = 1'b1;
        nxt      = S_FETCH;
      end
      default: begin
        c.trap       = 1'b1;
        c.trap_cause = cause_q;
        nxt          = S_TRAP;
      end
    endcase
  end

  // Outputs are forced low combinationally for the whole time rst is asserted.
  assign o = rst ? '0 : c;

  assign bus.mem_rd     = o.mem_rd;
  assign bus.mem_wr     = o.mem_wr;
  assign bus.i_or_d     = o.i_or_d;
  assign bus.ir_wr      = o.ir_wr;
  assign bus.pc_wr      = o.pc_wr;
  assign bus.pc_src     = o.pc_src;
  assign bus.alu_src_a  = o.alu_src_a;
  assign bus.alu_src_b  = o.alu_src_b;
  assign bus.alu_op     = o.alu_op;
  assign bus.ext_op     = o.ext_op;
  assign bus.reg_dst    = o.reg_dst;
  assign bus.mem_to_reg = o.mem_to_reg;
  assign bus.reg_wr     = o.reg_wr;
  assign bus.retire     = o.retire;
  assign bus.trap       = o.trap;
  assign bus.trap_cause = o.trap_cause;
  assign bus.state      = o.state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle vector table for the main
// instruction flows plus hand-written sequences for waits, timeouts, traps and reset.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();
  multicycle_ctrl_if bus2 ();

  assign bus2.inst    = bus.inst;
  assign bus2.zero    = bus.zero;
  assign bus2.mem_ack = bus.mem_ack;

  multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic        r;
    logic [31:0] inst;
    logic        z;
    logic        ack;
    logic [3:0]  st;
    logic [7:0]  strb;  // {mem_rd, mem_wr, i_or_d, ir_wr, pc_wr, reg_wr, retire, trap}
    logic [1:0]  pcs;
    logic [1:0]  srcb;
    logic [2:0]  aop;
    logic [3:0]  misc;  // {alu_src_a, ext_op, reg_dst, mem_to_reg}
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [31:0] I_ADDI = 32'h20050001;
  localparam logic [31:0] I_LW   = 32'h8C820004;
  localparam logic [31:0] I_SW   = 32'hAC820004;
  localparam logic [31:0] I_BEQ  = 32'h10000003;
  localparam logic [31:0] I_BNE  = 32'h14000003;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_ADD  = 32'h00A62020;
  localparam logic [31:0] I_ILL  = 32'hFC000000;
  localparam logic [31:0] I_BADF = 32'h00000001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] i, input logic z, input logic a);
    @(negedge clk);
    rst         = r;
    bus.inst    = i;
    bus.zero    = z;
    bus.mem_ack = a;
    #2;
  endtask

  task automatic v(input logic r, input logic [31:0] i, input logic z, input logic a,
                   input logic [3:0] st, input logic [7:0] sb, input logic [1:0] pcs,
                   input logic [1:0] srcb, input logic [2:0] aop, input logic [3:0] misc);
    vec_t e;
    e = '{r: r, inst: i, z: z, ack: a, st: st, strb: sb, pcs: pcs, srcb: srcb, aop: aop, misc: misc};
    vecs.push_back(e);
  endtask

  function automatic logic [7:0] strobes();
    return {bus.mem_rd, bus.mem_wr, bus.i_or_d, bus.ir_wr, bus.pc_wr,
            bus.reg_wr, bus.retire, bus.trap};
  endfunction

  task automatic fetch_decode(input logic [31:0] i, input logic z);
    v(0, i, z, 1, 4'd0, 8'b1001_1000, 2'b00, 2'b01, 3'b000, 4'b0000);
    v(0, i, z, 1, 4'd1, 8'b0000_0000, 2'b00, 2'b11, 3'b000, 4'b0100);
  endtask

  initial begin
    logic [31:0] r_inst[5];
    logic [2:0]  r_aop[5];
    logic [31:0] b_inst[4];
    logic        b_zero[4];
    logic        b_take[4];

    bus.inst    = '0;
    bus.zero    = 1'b0;
    bus.mem_ack = 1'b0;

    // ---- vector table ----
    v(1, 32'h0, 0, 0, 4'd0, 8'h00, 2'b00, 2'b00, 3'b000, 4'b0000);
    fetch_decode(I_ADDI, 0);
    v(0, I_ADDI, 0, 1, 4'd8, 8'b0000_0000, 2'b00, 2'b10, 3'b000, 4'b1100);
    v(0, I_ADDI, 0, 1, 4'd9, 8'b0000_0110, 2'b00, 2'b00, 3'b000, 4'b0000);

    r_inst = '{32'h00A62022, 32'h00A62024, 32'h00A62025, 32'h00A6202A, 32'h00052080};
    r_aop  = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
    for (int k = 0; k < 5; k++) begin
      fetch_decode(r_inst[k], 0);
      v(0, r_inst[k], 0, 1, 4'd6, 8'b0000_0000, 2'b00, 2'b00, r_aop[k], 4'b1000);
      v(0, r_inst[k], 0, 1, 4'd7, 8'b0000_0110, 2'b00, 2'b00, r_aop[k], 4'b0010);
    end

    fetch_decode(I_SW, 0);
    v(0, I_SW, 0, 1, 4'd2, 8'b0000_0000, 2'b00, 2'b10, 3'b000, 4'b1100);
    v(0, I_SW, 0, 0, 4'd5, 8'b0110_0000, 2'b00, 2'b00, 3'b000, 4'b0000);
    v(0, I_SW, 0, 1, 4'd5, 8'b0110_0010, 2'b00, 2'b00, 3'b000, 4'b0000);

    b_inst = '{I_BEQ, I_BEQ, I_BNE, I_BNE};
    b_zero = '{1'b1, 1'b0, 1'b1, 1'b0};
    b_take = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      fetch_decode(b_inst[k], b_zero[k]);
      v(0, b_inst[k], b_zero[k], 1, 4'd10, b_take[k] ? 8'b0000_1010 : 8'b0000_0010,
        2'b01, 2'b00, 3'b001, 4'b1000);
    end

    fetch_decode(I_J, 0);
    v(0, I_J, 0, 1, 4'd11, 8'b0000_1010, 2'b10, 2'b00, 3'b000, 4'b0000);
    v(0, I_J, 0, 0, 4'd0, 8'b1000_0000, 2'b00, 2'b01, 3'b000, 4'b0000);

    foreach (vecs[k]) begin
      drive(vecs[k].r, vecs[k].inst, vecs[k].z, vecs[k].ack);
      chk($sformatf("vec%0d.state", k), bus.state, vecs[k].st);
      chk($sformatf("vec%0d.strobes", k), strobes(), vecs[k].strb);
      chk($sformatf("vec%0d.pc_src", k), bus.pc_src, vecs[k].pcs);
      chk($sformatf("vec%0d.alu_src_b", k), bus.alu_src_b, vecs[k].srcb);
      chk($sformatf("vec%0d.alu_op", k), bus.alu_op, vecs[k].aop);
      chk($sformatf("vec%0d.misc", k),
          {bus.alu_src_a, bus.ext_op, bus.reg_dst, bus.mem_to_reg}, vecs[k].misc);
    end

    // ---- lw with three wait cycles in MEM_READ: 8 cycles total ----
    drive(1, 32'h0, 0, 0);
    drive(0, I_LW, 0, 1); chk("lw.fetch", bus.state, 4'd0);
    drive(0, I_LW, 0, 1); chk("lw.decode", bus.state, 4'd1);
    drive(0, I_LW, 0, 1); chk("lw.addr", bus.state, 4'd2);
    for (int k = 0; k < 3; k++) begin
      drive(0, I_LW, 0, 0);
      chk("lw.wait", {bus.state, bus.mem_rd, bus.i_or_d, bus.retire}, {4'd3, 3'b110});
    end
    drive(0, I_LW, 0, 1);
    chk("lw.ack", {bus.state, bus.mem_rd, bus.i_or_d}, {4'd3, 2'b11});
    drive(0, I_LW, 0, 0);
    chk("lw.wb", {bus.state, bus.reg_wr, bus.mem_to_reg, bus.reg_dst, bus.retire},
        {4'd4, 4'b1101});
    drive(0, I_LW, 0, 0); chk("lw.next_fetch", {bus.state, bus.retire}, {4'd0, 1'b0});

    // ---- fetch timeout: TRAP exactly 16 cycles after FETCH entry ----
    drive(1, 32'h0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      drive(0, I_ADDI, 0, 0);
      chk("tmo.waiting", {bus.state, bus.trap, bus.mem_rd}, {4'd0, 2'b01});
    end
    drive(0, I_ADDI, 0, 0);
    chk("tmo.trap", {bus.state, bus.trap, bus.trap_cause, bus.mem_rd}, {4'd15, 1'b1, 2'b10, 1'b0});
    chk("tmo.nop_inst_trap", {bus2.state, bus2.trap_cause}, {4'd15, 2'b10});
    drive(0, I_ADDI, 0, 1);
    chk("tmo.sticky", {bus.state, bus.trap_cause, bus.ir_wr}, {4'd15, 2'b10, 1'b0});

    // ---- ack on the 16th fetch cycle wins over the timeout ----
    drive(1, 32'h0, 0, 0);
    for (int k = 0; k < 15; k++) drive(0, I_ADDI, 0, 0);
    drive(0, I_ADDI, 0, 1);
    chk("ack_at_limit.ir_wr", {bus.state, bus.ir_wr, bus.pc_wr}, {4'd0, 2'b11});
    drive(0, I_ADDI, 0, 1);
    chk("ack_at_limit.decode", {bus.state, bus.trap}, {4'd1, 1'b0});

    // ---- illegal opcode: trap for 20 cycles; the NOP variant returns to FETCH ----
    drive(1, 32'h0, 0, 0);
    drive(0, I_ILL, 0, 1);
    drive(0, I_ILL, 0, 1); chk("ill.decode", bus.state, 4'd1);
    for (int k = 0; k < 20; k++) begin
      drive(0, I_ILL, 0, 1);
      chk("ill.trap", {bus.state, bus.trap, bus.trap_cause, bus.mem_rd, bus.retire},
          {4'd15, 1'b1, 2'b01, 2'b00});
      if (k == 0) chk("ill.nop_fetch", {bus2.state, bus2.trap, bus2.retire}, {4'd0, 2'b00});
    end
    drive(1, I_ILL, 0, 0);
    chk("ill.rst", {bus.state, bus.trap, bus.trap_cause}, {4'd0, 3'b000});
    drive(0, I_ILL, 0, 0);
    chk("ill.after_rst", {bus.state, bus.mem_rd, bus.trap}, {4'd0, 2'b10});

    // ---- R-type with undefined funct traps as illegal ----
    drive(1, 32'h0, 0, 0);
    drive(0, I_BADF, 0, 1);
    drive(0, I_BADF, 0, 1);
    drive(0, I_BADF, 0, 1);
    chk("badfunct.trap", {bus.state, bus.trap_cause}, {4'd15, 2'b01});

    // ---- asynchronous reset in the middle of R_WB ----
    drive(1, 32'h0, 0, 0);
    drive(0, I_ADD, 0, 1);
    drive(0, I_ADD, 0, 1);
    drive(0, I_ADD, 0, 1); chk("arst.exec", {bus.state, bus.alu_op}, {4'd6, 3'b000});
    drive(0, I_ADD, 0, 1); chk("arst.rwb", {bus.state, bus.reg_wr}, {4'd7, 1'b1});
    #1 rst = 1'b1;
    #1 chk("arst.async", {bus.state, bus.reg_wr, bus.retire, bus.mem_rd}, {4'd0, 3'b000});
    drive(0, I_ADD, 0, 0);
    chk("arst.first_fetch", {bus.state, bus.mem_rd, bus.i_or_d, bus.alu_src_b},
        {4'd0, 2'b10, 2'b01});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
